// File: rtl/alu_pkg.sv
// Shared opcodes, data types, FSM and datapath-mode encodings for alu_seq.
package alu_pkg;
  localparam logic [3:0] DT_SIGNED   = 4'h1;
  localparam logic [3:0] DT_UNSIGNED = 4'h2;

  localparam logic [4:0] OP_ADD = 5'h01;
  localparam logic [4:0] OP_SUB = 5'h02;
  localparam logic [4:0] OP_MUL = 5'h03;
  localparam logic [4:0] OP_DIV = 5'h04;

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_e;
  typedef enum logic {MODE_MUL, MODE_DIV} mode_e;
endpackage

// File: rtl/alu_if.sv
// Command/result bundle between the command parser (master) and the ALU (slave).
interface alu_if #(parameter int WIDTH = 16);
  logic [3:0]         dtype;
  logic [4:0]         operator;
  logic [WIDTH-1:0]   src1;
  logic [WIDTH-1:0]   src2;
  logic               start;
  logic               busy;
  logic               alu_done;
  logic [2*WIDTH-1:0] calc_res;
  logic [WIDTH-1:0]   calc_rem;
  logic               err;

  modport master (
    output dtype, operator, src1, src2, start,
    input  busy, alu_done, calc_res, calc_rem, err
  );

  modport slave (
    input  dtype, operator, src1, src2, start,
    output busy, alu_done, calc_res, calc_rem, err
  );
endinterface

// File: rtl/alu_iter_core.sv
// One-bit-per-step magnitude datapath: shift-add multiply or restoring divide.
// Operands captured on load; each step retires one bit; no backpressure.
module alu_iter_core
  import alu_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic               step,
  input  mode_e              mode,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic [2*WIDTH-1:0] prod,
  output logic [WIDTH-1:0]   quot,
  output logic [WIDTH-1:0]   rem
);
  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d, b_q, b_d;
  mode_e            mode_q, mode_d;
  logic [WIDTH:0]   sum, shifted, diff;
  logic             ge;

  // hi:lo is the product accumulator for mul, remainder:quotient for div.
  always_comb begin
    sum     = {1'b0, hi_q} + {1'b0, {WIDTH{lo_q[0]}} & b_q};
    shifted = {hi_q, lo_q[WIDTH-1]};
    diff    = shifted - {1'b0, b_q};
    ge      = (shifted >= {1'b0, b_q});
    hi_d    = hi_q;
    lo_d    = lo_q;
    b_d     = b_q;
    mode_d  = mode_q;
    if (load) begin
      hi_d   = '0;
      lo_d   = a;
      b_d    = b;
      mode_d = mode;
    end else if (step) begin
      if (mode_q == MODE_MUL) begin
        hi_d = sum[WIDTH:1];
        lo_d = {sum[0], lo_q[WIDTH-1:1]};
      end else begin
        hi_d = ge ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
        lo_d = {lo_q[WIDTH-2:0], ge};
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hi_q   <= '0;
      lo_q   <= '0;
      b_q    <= '0;
      mode_q <= MODE_MUL;
    end else begin
      hi_q   <= hi_d;
      lo_q   <= lo_d;
      b_q    <= b_d;
      mode_q <= mode_d;
    end
  end

  assign prod = {hi_q, lo_q};
  assign quot = lo_q;
  assign rem  = hi_q;
endmodule

// File: rtl/alu_seq.sv
// Sequential signed/unsigned add/sub/mul/div with busy/done handshake and held results.
// add/sub/error: done 1 cycle after start; mul/div: WIDTH+2; start ignored unless IDLE.
module alu_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic  clk,
  input  logic  rst,
  alu_if.slave  bus
);
  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [3:0]         dtype_q, dtype_d;
  logic [4:0]         op_q, op_d;
  logic [WIDTH-1:0]   src1_q, src1_d, src2_q, src2_d;
  logic [2*WIDTH-1:0] res_q, res_d;
  logic [WIDTH-1:0]   rem_q, rem_d;
  logic               err_q, err_d, busy_q, busy_d, done_q, done_d;

  logic               in_signed, in_legal, lat_signed, neg_res, neg_rem;
  logic [2*WIDTH-1:0] ext1, ext2, quot_ext, prod_fix, quot_fix;
  logic [WIDTH-1:0]   mag1, mag2, rem_fix;
  logic               core_load, core_step;
  mode_e              core_mode;
  logic [2*WIDTH-1:0] core_prod;
  logic [WIDTH-1:0]   core_quot, core_rem;

  alu_iter_core #(.WIDTH(WIDTH)) u_core (
    .clk  (clk),
    .rst  (rst),
    .load (core_load),
    .step (core_step),
    .mode (core_mode),
    .a    (mag1),
    .b    (mag2),
    .prod (core_prod),
    .quot (core_quot),
    .rem  (core_rem)
  );

  always_comb begin
    in_signed = (bus.dtype == DT_SIGNED);
    in_legal  = ((bus.dtype == DT_SIGNED) || (bus.dtype == DT_UNSIGNED)) &&
                (bus.operator >= OP_ADD) && (bus.operator <= OP_DIV);
    ext1      = {{WIDTH{in_signed & bus.src1[WIDTH-1]}}, bus.src1};
    ext2      = {{WIDTH{in_signed & bus.src2[WIDTH-1]}}, bus.src2};
    // Most-negative maps to itself, which reads correctly as an unsigned magnitude.
    mag1      = (in_signed && bus.src1[WIDTH-1]) ? -bus.src1 : bus.src1;
    mag2      = (in_signed && bus.src2[WIDTH-1]) ? -bus.src2 : bus.src2;
    core_mode = (bus.operator == OP_DIV) ? MODE_DIV : MODE_MUL;

    lat_signed = (dtype_q == DT_SIGNED);
    neg_res    = lat_signed & (src1_q[WIDTH-1] ^ src2_q[WIDTH-1]);
    neg_rem    = lat_signed & src1_q[WIDTH-1];
    prod_fix   = neg_res ? -core_prod : core_prod;
    // Negating at 2*WIDTH keeps most-negative / -1 as a positive quotient.
    quot_ext   = {{WIDTH{1'b0}}, core_quot};
    quot_fix   = neg_res ? -quot_ext : quot_ext;
    rem_fix    = neg_rem ? -core_rem : core_rem;
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    dtype_d   = dtype_q;
    op_d      = op_q;
    src1_d    = src1_q;
    src2_d    = src2_q;
    res_d     = res_q;
    rem_d     = rem_q;
    err_d     = err_q;
    core_load = 1'b0;
    core_step = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          dtype_d = bus.dtype;
          op_d    = bus.operator;
          src1_d  = bus.src1;
          src2_d  = bus.src2;
          res_d   = '0;
          rem_d   = '0;
          err_d   = 1'b0;
          state_d = DONE;
          if (!in_legal) begin
            err_d = 1'b1;
          end else begin
            case (bus.operator)
              OP_ADD: res_d = ext1 + ext2;
              OP_SUB: res_d = ext1 - ext2;
              OP_MUL: begin
                state_d   = CALC;
                cnt_d     = '0;
                core_load = 1'b1;
              end
              OP_DIV: begin
                if (bus.src2 == '0) begin
                  err_d = 1'b1;
                  res_d = '1;
                  rem_d = bus.src1;
                end else begin
                  state_d   = CALC;
                  cnt_d     = '0;
                  core_load = 1'b1;
                end
              end
              default: err_d = 1'b1;
            endcase
          end
        end
      end
      CALC: begin
        core_step = 1'b1;
        cnt_d     = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(WIDTH - 1)) state_d = FIX;
      end
      FIX: begin
        state_d = DONE;
        if (op_q == OP_DIV) begin
          res_d = quot_fix;
          rem_d = rem_fix;
        end else begin
          res_d = prod_fix;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    busy_d = (state_d == CALC) || (state_d == FIX);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      dtype_q <= '0;
      op_q    <= '0;
      src1_q  <= '0;
      src2_q  <= '0;
      res_q   <= '0;
      rem_q   <= '0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dtype_q <= dtype_d;
      op_q    <= op_d;
      src1_q  <= src1_d;
      src2_q  <= src2_d;
      res_q   <= res_d;
      rem_q   <= rem_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign bus.busy     = busy_q;
  assign bus.alu_done = done_q;
  assign bus.calc_res = res_q;
  assign bus.calc_rem = rem_q;
  assign bus.err      = err_q;
endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq at WIDTH=16 with hand-computed expectations.
module tb_alu_seq;
  import alu_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  alu_if #(.WIDTH(16)) bus();
  alu_seq #(.WIDTH(16)) dut (.clk(clk), .rst(rst), .bus(bus));

  int   checks = 0;
  int   errors = 0;
  int   lat;
  int   seen;
  logic b1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [3:0] dt, input logic [4:0] op,
                       input logic [15:0] a, input logic [15:0] b);
    bus.dtype    = dt;
    bus.operator = op;
    bus.src1     = a;
    bus.src2     = b;
  endtask

  // Caller is 1 time unit after an edge with the DUT in IDLE; returns in the
  // cycle alu_done is seen (or when the budget runs out). lat=1 means cycle N+1.
  task automatic run_op(input logic [3:0] dt, input logic [4:0] op,
                        input logic [15:0] a, input logic [15:0] b,
                        output int l, output logic bz);
    drive(dt, op, a, b);
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    l  = 1;
    bz = bus.busy;
    while (bus.alu_done !== 1'b1 && l < 60) begin
      @(posedge clk); #1;
      l++;
    end
  endtask

  task automatic wait_done(inout int l);
    while (bus.alu_done !== 1'b1 && l < 60) begin
      @(posedge clk); #1;
      l++;
    end
  endtask

  initial begin
    drive(4'h0, 5'h00, 16'h0, 16'h0);
    bus.start = 1'b0;
    #2;
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.alu_done, 0);
    chk("rst_err",  bus.err, 0);
    chk("rst_res",  bus.calc_res, 0);
    chk("rst_rem",  bus.calc_rem, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    run_op(DT_SIGNED, OP_ADD, 16'h7FFF, 16'h0001, lat, b1);
    chk("sadd_res", bus.calc_res, 64'h0000_8000);
    chk("sadd_lat", lat, 1);
    chk("sadd_busy", b1, 0);
    chk("sadd_err", bus.err, 0);
    @(posedge clk); #1;
    chk("done_pulse", bus.alu_done, 0);
    chk("hold_res", bus.calc_res, 64'h0000_8000);

    run_op(DT_UNSIGNED, OP_ADD, 16'hFFFF, 16'h0001, lat, b1);
    chk("uadd_res", bus.calc_res, 64'h0001_0000);
    @(posedge clk); #1;
    run_op(DT_SIGNED, OP_SUB, 16'h8000, 16'h0001, lat, b1);
    chk("ssub_res", bus.calc_res, 64'hFFFF_7FFF);

    // start raised during the DONE cycle must be dropped
    drive(DT_SIGNED, OP_ADD, 16'h0001, 16'h0001);
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    chk("done_ign_pulse", bus.alu_done, 0);
    chk("done_ign_res", bus.calc_res, 64'hFFFF_7FFF);

    run_op(DT_SIGNED, OP_MUL, 16'hFFFD, 16'h0007, lat, b1);
    chk("smul_res", bus.calc_res, 64'hFFFF_FFEB);
    chk("smul_lat", lat, 18);
    chk("smul_busy", b1, 1);
    chk("smul_rem", bus.calc_rem, 0);
    @(posedge clk); #1;
    run_op(DT_UNSIGNED, OP_MUL, 16'hFFFF, 16'hFFFF, lat, b1);
    chk("umul_res", bus.calc_res, 64'hFFFE_0001);
    @(posedge clk); #1;
    run_op(DT_SIGNED, OP_MUL, 16'h8000, 16'h8000, lat, b1);
    chk("smul_min_res", bus.calc_res, 64'h4000_0000);
    @(posedge clk); #1;

    run_op(DT_SIGNED, OP_DIV, 16'hFFF9, 16'h0002, lat, b1);
    chk("sdiv_res", bus.calc_res, 64'hFFFF_FFFD);
    chk("sdiv_rem", bus.calc_rem, 64'hFFFF);
    chk("sdiv_lat", lat, 18);
    @(posedge clk); #1;
    run_op(DT_UNSIGNED, OP_DIV, 16'd100, 16'd7, lat, b1);
    chk("udiv_res", bus.calc_res, 64'd14);
    chk("udiv_rem", bus.calc_rem, 64'd2);
    @(posedge clk); #1;
    run_op(DT_SIGNED, OP_DIV, 16'h8000, 16'hFFFF, lat, b1);
    chk("sdiv_ovf_res", bus.calc_res, 64'h0000_8000);
    chk("sdiv_ovf_err", bus.err, 0);
    chk("sdiv_ovf_rem", bus.calc_rem, 0);
    @(posedge clk); #1;

    run_op(DT_SIGNED, OP_DIV, 16'h1234, 16'h0000, lat, b1);
    chk("div0_lat", lat, 1);
    chk("div0_err", bus.err, 1);
    chk("div0_res", bus.calc_res, 64'hFFFF_FFFF);
    chk("div0_rem", bus.calc_rem, 64'h1234);
    @(posedge clk); #1;

    // results cleared the cycle after a new start is accepted
    drive(DT_UNSIGNED, OP_MUL, 16'd3, 16'd4);
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    lat = 1;
    chk("clr_res", bus.calc_res, 0);
    chk("clr_rem", bus.calc_rem, 0);
    chk("clr_err", bus.err, 0);
    chk("clr_busy", bus.busy, 1);
    wait_done(lat);
    chk("umul_small_res", bus.calc_res, 64'd12);
    chk("umul_small_lat", lat, 18);
    @(posedge clk); #1;

    run_op(DT_SIGNED, 5'h05, 16'h0003, 16'h0004, lat, b1);
    chk("ill_op_err", bus.err, 1);
    chk("ill_op_res", bus.calc_res, 0);
    chk("ill_op_lat", lat, 1);
    @(posedge clk); #1;
    run_op(4'h3, OP_ADD, 16'h0001, 16'h0001, lat, b1);
    chk("ill_dt_err", bus.err, 1);
    chk("ill_dt_res", bus.calc_res, 0);
    @(posedge clk); #1;

    // start pulse with new operands mid-multiply is ignored
    drive(DT_SIGNED, OP_MUL, 16'd3, 16'd5);
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    lat = 1;
    while (lat < 5) begin
      @(posedge clk); #1;
      lat++;
    end
    drive(DT_UNSIGNED, OP_ADD, 16'd9, 16'd9);
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    lat++;
    wait_done(lat);
    chk("busy_ign_res", bus.calc_res, 64'd15);
    chk("busy_ign_lat", lat, 18);
    @(posedge clk); #1;

    // back-to-back: second start in the cycle after alu_done
    run_op(DT_UNSIGNED, OP_DIV, 16'd1000, 16'd33, lat, b1);
    chk("b2b_div_res", bus.calc_res, 64'd30);
    chk("b2b_div_rem", bus.calc_rem, 64'd10);
    @(posedge clk); #1;
    run_op(DT_UNSIGNED, OP_ADD, 16'd2, 16'd3, lat, b1);
    chk("b2b_add_res", bus.calc_res, 64'd5);
    chk("b2b_add_lat", lat, 1);
    @(posedge clk); #1;

    // async reset in the middle of a multiply
    drive(DT_SIGNED, OP_MUL, 16'h0123, 16'h0045);
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    lat = 1;
    while (lat < 8) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("pre_rst_busy", bus.busy, 1);
    rst = 1'b1;
    #1;
    chk("mid_rst_busy", bus.busy, 0);
    chk("mid_rst_done", bus.alu_done, 0);
    chk("mid_rst_res", bus.calc_res, 0);
    chk("mid_rst_rem", bus.calc_rem, 0);
    chk("mid_rst_err", bus.err, 0);
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    repeat (25) begin
      @(posedge clk); #1;
      if (bus.alu_done === 1'b1) seen++;
    end
    chk("post_rst_no_done", seen, 0);
    chk("post_rst_busy", bus.busy, 0);
    run_op(DT_SIGNED, OP_ADD, 16'hFFFF, 16'hFFFF, lat, b1);
    chk("post_rst_add", bus.calc_res, 64'hFFFF_FFFE);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
